// File: rtl/otter_pkg.sv
// Shared OTTER definitions: NOP encoding, cache geometry defaults, icache FSM states.
package otter_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] NOP          = 32'h00000013;
  localparam int unsigned ICACHE_LINES = 16;
  localparam int unsigned ICACHE_WORDS = 8;

  typedef enum logic {IDLE, FILL} icache_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data store: one fill write port, one registered fetch read port.
module icache_data_ram #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 8,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned OFF_W = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [IDX_W-1:0] w_idx,
  input  logic [OFF_W-1:0] w_off,
  input  logic [31:0]      w_data,
  input  logic             re,
  input  logic [IDX_W-1:0] r_idx,
  input  logic [OFF_W-1:0] r_off,
  output logic [31:0]      r_data
);

  logic [31:0] mem [LINES*WORDS];

  always_ff @(posedge CLK) begin
    if (we) mem[{w_idx, w_off}] <= w_data;
    if (re) r_data <= mem[{r_idx, r_off}];
  end

endmodule

// File: rtl/otter_icache.sv
// Direct-mapped read-only instruction cache for the OTTER IF stage.
// One-cycle hits; misses stall while the line is filled word-serially from word 0.
module otter_icache
  import otter_pkg::*;
#(
  parameter int unsigned LINES = ICACHE_LINES,
  parameter int unsigned WORDS = ICACHE_WORDS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_rden,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned OFF = $clog2(WORDS);
  localparam int unsigned IDX = $clog2(LINES);
  localparam int unsigned TAG = XLEN - 2 - OFF - IDX;

  logic [OFF-1:0] off;
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic           unused_addr_lsb;

  assign off             = cpu_addr[OFF+1:2];
  assign idx             = cpu_addr[OFF+IDX+1:OFF+2];
  assign tag             = cpu_addr[31:OFF+IDX+2];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  icache_state_t  state_q, state_d;
  logic [TAG-1:0] tag_arr [LINES];
  logic [LINES-1:0] valid_q;
  logic [TAG-1:0] fill_tag;
  logic [IDX-1:0] fill_idx;
  logic [OFF-1:0] cnt_q;
  logic           flush_pend;
  logic           instr_sel;
  logic [31:0]    ram_q;
  logic           hit;
  logic           start_fill, fill_we, fill_last;

  assign hit       = (state_q == IDLE) && valid_q[idx] && (tag_arr[idx] == tag);
  assign cpu_stall = cpu_rden && !hit;
  assign cpu_instr = instr_sel ? ram_q : NOP;

  // Next-state and fill strobes.
  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_rden && !hit && !flush) begin
          start_fill = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_we = 1'b1;
          if (cnt_q == OFF'(WORDS - 1)) begin
            fill_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      cnt_q      <= '0;
      flush_pend <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      instr_sel  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) valid_q <= '0;
      if (flush && state_q == FILL && !fill_last) flush_pend <= 1'b1;
      if (start_fill) begin
        fill_tag <= tag;
        fill_idx <= idx;
        cnt_q    <= '0;
        mem_req  <= 1'b1;
        mem_addr <= {tag, idx, {OFF{1'b0}}, 2'b00};
        miss_cnt <= sat_inc(miss_cnt);
      end
      if (fill_we) begin
        cnt_q <= cnt_q + OFF'(1);
        if (!fill_last) mem_addr <= {fill_tag, fill_idx, cnt_q + OFF'(1), 2'b00};
      end
      // Line that saw a flush at any point of its fill is left invalid.
      if (fill_last) begin
        valid_q[fill_idx] <= !flush_pend && !flush;
        flush_pend        <= 1'b0;
        mem_req           <= 1'b0;
      end
      if (cpu_rden) instr_sel <= hit;
      if (cpu_rden && hit) hit_cnt <= sat_inc(hit_cnt);
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_last) tag_arr[fill_idx] <= fill_tag;
  end

  icache_data_ram #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_data (
    .CLK   (CLK),
    .we    (fill_we),
    .w_idx (fill_idx),
    .w_off (cnt_q),
    .w_data(mem_rdata),
    .re    (cpu_rden && hit),
    .r_idx (idx),
    .r_off (off),
    .r_data(ram_q)
  );

endmodule

// File: doc/otter_icache.md
Name: otter_icache

Overview:
- Direct-mapped, read-only instruction cache between the pipelined OTTER IF stage and a slower, word-serial backing memory.
- Serves the fetch port with one-cycle hit latency, matching the synchronous instruction-memory timing the IF stage expects.
- Asserts a stall to hold the PC and the IF/DE register during a line fill.
- Supports full invalidation for FENCE.I and self-modifying-code flows.

Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2.
- WORDS, 8, 32-bit words per line; power of 2, ≥2.
- Derived: OFF=log2(WORDS), IDX=log2(LINES), TAG=30-OFF-IDX.
- Address split: word offset [OFF+1:2], index [OFF+IDX+1:OFF+2], tag [31:OFF+IDX+2], bits [1:0] ignored.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- cpu_rden  in  1  fetch request this cycle.
- cpu_addr  in  32  fetch byte address (PC).
- cpu_instr  out  32  instruction; registered; valid the cycle after an unstalled request.
- cpu_stall  out  1  combinational; high when cpu_rden is high and the request cannot be served this cycle.
- flush  in  1  invalidate all lines.
- mem_req  out  1  backing-memory word read request.
- mem_addr  out  32  word-aligned backing address.
- mem_ack  in  1  mem_rdata valid; one word consumed.
- mem_rdata  in  32  backing read data.
- hit_cnt  out  32  saturating hit counter.
- miss_cnt  out  32  saturating miss counter.

Behaviour:
- Reset values: all valid bits 0, state IDLE, cpu_instr=32'h00000013 (NOP), mem_req=0, mem_addr=0, hit_cnt=0, miss_cnt=0, fill counter 0, flush_pend=0. Tag/data arrays are not reset.
- Hit (combinational): hit = state==IDLE && valid[idx] && tag_arr[idx]==tag.
- cpu_stall = cpu_rden && !hit. This covers both a miss in IDLE and any request while in FILL.
- Served hit, cycle N: cpu_instr <= data[idx][off] at edge N→N+1; hit_cnt++ (saturate at 32'hFFFFFFFF).
- Stalled request, cycle N: cpu_instr <= NOP. Not idle (cpu_rden=0): cpu_instr holds its value.
- FSM states: IDLE, FILL.
- IDLE→FILL: on cpu_rden && !hit && !flush. Latch fill_tag/fill_idx from cpu_addr, cnt=0, miss_cnt++ (saturating).
- FILL outputs: mem_req=1; mem_addr={fill_tag,fill_idx,cnt,2'b00}.
  - mem_addr is held stable until mem_ack; there is no request/ack timing limit.
  - On mem_ack: data[fill_idx][cnt] <= mem_rdata, cnt++.
  - Lines are always filled starting at word 0, not critical-word-first.
- FILL→IDLE: on mem_ack with cnt==WORDS-1. Write tag_arr[fill_idx]; valid[fill_idx] <= !flush_pend && !flush; clear flush_pend; mem_req drops next cycle.
  - The stalled request is re-evaluated in the following IDLE cycle.
  - Miss penalty = sum of ack waits + 1 cycle.
- cpu_addr may change during FILL (taken branch): the fill still completes, then the new address is looked up.
- flush in IDLE: all valid bits cleared at the edge. Any hit that cycle is still served with old data; the miss transition is suppressed.
- flush in FILL: all valid bits cleared and flush_pend set. The in-flight line completes but is left invalid.
- RESET mid-fill: return to IDLE and clear everything per the reset values; mem_req=0 on the next cycle. The backing memory shares RESET, so it must tolerate an abandoned request.

Decomposition:
- Shared package otter_pkg: NOP constant 32'h00000013, icache_state_t enum {IDLE, FILL}, address-slicing localparams.
- One sub-module, icache_data_ram: LINES*WORDS x 32.
  - Write port: fill_idx, cnt, mem_rdata, we=mem_ack in FILL.
  - Read port: idx, off, registered output.
  - Top-level cpu_instr is muxed to NOP on a stall.
- Tag and valid arrays stay in the top level as flops.

Test Plan:
- Cold miss: reset, cpu_rden=1, addr 0x0, mem_ack each cycle with mem_rdata=0x1000+addr → cpu_stall high for 9 cycles; mem_addr steps 0x00..0x1C; cpu_instr=0x1000 the cycle after cpu_stall drops; miss_cnt=1.
- Sequential hits: addrs 0x4..0x1C back-to-back → no stall; cpu_instr=0x1004..0x101C one cycle later each; hit_cnt increases by 7.
- Conflict: 0x200 (index 0, new tag) → miss with fills 0x200..0x21C; then 0x0 misses again; miss_cnt=3.
- Slow memory: mem_ack every 3rd cycle → mem_addr stable between acks; data correct; stall lasts 24+1 cycles.
- Flush during fill: assert flush at word 3 → all 8 acks still consumed; the same address then misses again; previously valid lines also miss.
- Reset mid-fill: RESET at word 5 → mem_req=0 next cycle, cpu_instr=NOP, counters 0; fetch 0x0 stalls and refills from word 0.
